// File: rtl/arm_seq_pkg.sv
// Shared types and defaults for the instruction sequencer.
// Holds the state enum, the NOP word and the default parameter values.
package arm_seq_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int WIDTH_DEF = 32;
  localparam int GAP_W_DEF = 3;

  localparam logic [WIDTH_DEF-1:0] NOP = '0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP,
    DONE
  } seq_state_e;

endpackage

// File: rtl/seq_mem.sv
// Program store: DEPTH x WIDTH, one synchronous write port, one async read.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (combinational read).
module seq_mem
  import arm_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset: program contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Plays a stored program onto Instruction, with NOP gaps, stall and stop.
// Ports: clk, reset (async, low), wr_* program port, count/nop_gap/start/
// stop/loop/stall controls; Instruction, instr_valid, issue_idx, busy,
// done outputs. Loop support is built in only with INSTR_SEQ_LOOP_EN.
module instr_sequencer
  import arm_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH):0]   count,
  input  logic [GAP_W-1:0]         nop_gap,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  input  logic                     stall,
  output logic [WIDTH-1:0]         Instruction,
  output logic                     instr_valid,
  output logic [$clog2(DEPTH)-1:0] issue_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  seq_state_e       state, nstate;
  logic [AW-1:0]    idx, nidx, step;
  logic [GAP_W-1:0] gcnt, ngcnt;
  logic [GAP_W-1:0] gap_q, ngap;
  logic [CW-1:0]    cnt_q, ncnt, cnt_in;
  logic             loop_q, nloop, loop_in;
  logic             last, upd;
  logic [WIDTH-1:0] rdata;

`ifdef INSTR_SEQ_LOOP_EN
  assign loop_in = loop;
`else
  logic unused_loop;
  assign unused_loop = loop;
  assign loop_in = 1'b0;
`endif

  seq_mem #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_en && (state == IDLE)),
    .waddr(wr_addr),
    .wdata(wr_data),
    .raddr(nidx),
    .rdata(rdata)
  );

  assign cnt_in = (count > DEPTH_C) ? DEPTH_C : count;
  assign last   = ({1'b0, idx} == (cnt_q - CW'(1)));
  // Wrap to slot 0 after the last slot (only reachable when looping).
  assign step   = last ? '0 : idx + 1'b1;
  assign upd    = stop || !stall;

  always_comb begin
    nstate = state;
    nidx   = idx;
    ngcnt  = gcnt;
    ncnt   = cnt_q;
    ngap   = gap_q;
    nloop  = loop_q;
    if (stop) begin
      nstate = IDLE;
      nidx   = '0;
      ngcnt  = '0;
    end else if (!stall) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            ncnt   = cnt_in;
            ngap   = nop_gap;
            nloop  = loop_in;
            nidx   = '0;
            ngcnt  = '0;
            nstate = (cnt_in == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (last && !loop_q) begin
            nstate = DONE;
          end else if (gap_q != '0) begin
            nstate = GAP;
            ngcnt  = gap_q;
          end else begin
            nidx = step;
          end
        end
        GAP: begin
          if (gcnt == GAP_W'(1)) begin
            nstate = ISSUE;
            nidx   = step;
            ngcnt  = '0;
          end else begin
            ngcnt = gcnt - 1'b1;
          end
        end
        DONE: nstate = IDLE;
        default: nstate = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      gcnt        <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      loop_q      <= 1'b0;
      Instruction <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (upd) begin
      state       <= nstate;
      idx         <= nidx;
      gcnt        <= ngcnt;
      cnt_q       <= ncnt;
      gap_q       <= ngap;
      loop_q      <= nloop;
      Instruction <= (nstate == ISSUE) ? rdata : WIDTH'(NOP);
      instr_valid <= (nstate == ISSUE);
      busy        <= (nstate == ISSUE) || (nstate == GAP);
      done        <= (nstate == DONE);
    end
  end

  assign issue_idx = idx;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer against a trace-level model.
// Driver pushes expected per-cycle outputs; a monitor pops and compares.
module tb_instr_sequencer;

  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
  localparam int GAP_W = 3;
`ifdef INSTR_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  count;
  logic [2:0]  nop_gap;
  logic        start, stop, loop, stall;
  logic [31:0] Instruction;
  logic        instr_valid;
  logic [3:0]  issue_idx;
  logic        busy, done;

  instr_sequencer #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH),
    .GAP_W(GAP_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .count      (count),
    .nop_gap    (nop_gap),
    .start      (start),
    .stop       (stop),
    .loop       (loop),
    .stall      (stall),
    .Instruction(Instruction),
    .instr_valid(instr_valid),
    .issue_idx  (issue_idx),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ins;
    logic        v;
    logic [3:0]  idx;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t        sbq[$];
  exp_t        tr[$];
  logic [31:0] prog [DEPTH];
  int          n_chk = 0;
  int          n_pass = 0;

  function automatic exp_t mk(logic [31:0] i, logic v, logic [3:0] x,
                              logic b, logic d);
    exp_t e;
    e.ins  = i;
    e.v    = v;
    e.idx  = x;
    e.busy = b;
    e.done = d;
    return e;
  endfunction

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, req,
                  $time);
  endfunction

  // Expected output sequence from the playback rules: each slot once,
  // gap NOPs between slots (and after the last one when looping),
  // then a single done cycle and idle.
  function automatic void build(int n, int gap, bit lp);
    tr.delete();
    if (n == 0) begin
      tr.push_back(mk(0, 0, 0, 0, 1));
      tr.push_back(mk(0, 0, 0, 0, 0));
      return;
    end
    if (lp && LOOP_EN) begin
      for (int i = 0; tr.size() < 300; i++) begin
        tr.push_back(mk(prog[i % n], 1, 4'(i % n), 1, 0));
        for (int g = 0; g < gap; g++) tr.push_back(mk(0, 0, 0, 1, 0));
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        tr.push_back(mk(prog[i], 1, 4'(i), 1, 0));
        if (i < n - 1)
          for (int g = 0; g < gap; g++) tr.push_back(mk(0, 0, 0, 1, 0));
      end
      tr.push_back(mk(0, 0, 0, 0, 1));
      tr.push_back(mk(0, 0, 0, 0, 0));
    end
  endfunction

  // Monitor: one expected entry per clock edge while playback is checked.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("outs", {28'd0, Instruction, instr_valid, busy, done},
            {28'd0, e.ins, e.v, e.busy, e.done});
        if (e.v) chk("issue_idx", 64'(issue_idx), 64'(e.idx));
      end
    end
  end

  task automatic check_zero(string nm);
    chk(nm, {25'd0, Instruction, instr_valid, issue_idx, busy, done},
        64'd0);
  endtask

  task automatic load(int a, logic [31:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 4'(a);
    wr_data = d;
    prog[a] = d;
  endtask

  task automatic run(int cnt_raw, int gap, bit lp, int stall_pct,
                     int stop_at, int reset_at, logic [63:0] smask);
    int n;
    int p;
    int k;
    bit st;
    n = (cnt_raw > DEPTH) ? DEPTH : cnt_raw;
    p = 0;
    build(n, gap, lp);
    if (lp && LOOP_EN && stop_at < 0) stop_at = 30;
    @(negedge clk);
    wr_en   = 1'b0;
    start   = 1'b1;
    count   = 5'(cnt_raw);
    nop_gap = 3'(gap);
    loop    = lp;
    sbq.push_back(tr[0]);
    for (k = 1; k < 2000; k++) begin
      @(negedge clk);
      start   = 1'b0;
      stall   = 1'b0;
      stop    = 1'b0;
      wr_en   = 1'b0;
      count   = 5'($urandom_range(0, 31));
      nop_gap = 3'($urandom_range(0, 7));
      loop    = 1'($urandom_range(0, 1));
      if (p == tr.size() - 1) break;
      if (k == reset_at) begin
        reset = 1'b0;
        #1;
        check_zero("reset_mid");
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      if (tr[p].busy || tr[p].done) begin
        wr_en   = ($urandom_range(0, 3) == 0);
        wr_addr = 4'($urandom_range(0, 15));
        wr_data = $urandom;
      end
      if (tr[p].busy && $urandom_range(0, 4) == 0) start = 1'b1;
      if (k == stop_at) begin
        stop  = 1'b1;
        stall = 1'($urandom_range(0, 1));
        sbq.push_back(mk(0, 0, 0, 0, 0));
        @(negedge clk);
        stop  = 1'b0;
        stall = 1'b0;
        wr_en = 1'b0;
        start = 1'b0;
        return;
      end
      st = ((k < 64) ? smask[k] : 1'b0) ||
           ($urandom_range(0, 99) < stall_pct);
      stall = st;
      if (!st) p++;
      sbq.push_back(tr[p]);
    end
    if (k >= 2000) chk("timeout", 64'(k), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, g, sa;
    bit lp;
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    count   = '0;
    nop_gap = '0;
    start   = 1'b0;
    stop    = 1'b0;
    loop    = 1'b0;
    stall   = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b1;
    @(negedge clk);
    check_zero("after_reset");

    for (int i = 0; i < DEPTH; i++) load(i, $urandom);
    load(0, 32'hE2931001);
    load(1, 32'h00000000);
    load(2, 32'hE2532001);

    run(3, 0, 1'b0, 0, -1, -1, 64'd0);
    run(3, 2, 1'b0, 0, -1, -1, 64'd0);
    run(0, 0, 1'b0, 0, -1, -1, 64'd0);
    run(3, 0, 1'b0, 0, -1, -1, 64'h1C);
    run(2, 1, 1'b1, 0, 12, -1, 64'd0);
    run(3, 3, 1'b0, 0, -1, 2, 64'd0);
    run(3, 0, 1'b0, 0, -1, -1, 64'd0);
    run(31, 1, 1'b0, 10, -1, -1, 64'd0);

    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) load($urandom_range(0, 15), $urandom);
      c  = ($urandom_range(0, 7) == 0) ? $urandom_range(17, 31)
                                       : $urandom_range(0, 16);
      g  = $urandom_range(0, 7);
      lp = 1'($urandom_range(0, 1));
      sa = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 20) : -1;
      if (lp && LOOP_EN && sa < 0) sa = $urandom_range(5, 60);
      run(c, g, lp, 20, sa, -1, 64'd0);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
